// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the FP32 compare stage.
// Op codes 100/101 (FMIN/FMAX) are only decoded when FCMP_MINMAX_EN is defined.
package fcmp_pkg;

    typedef enum logic [2:0] {
        FCMP_FLE  = 3'b000,
        FCMP_FLT  = 3'b001,
        FCMP_FEQ  = 3'b010,
        FCMP_FMIN = 3'b100,
        FCMP_FMAX = 3'b101
    } fcmp_op_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam int unsigned FFLAG_NV  = 4;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == 8'hFF) && (x.mant != '0);
    endfunction

    function automatic logic is_snan(input fp32_t x);
        return is_nan(x) && !x.mant[22];
    endfunction

    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0) && (x.mant == '0);
    endfunction

    // Maps FP32 onto an unsigned key with the same total order (-0 sorts just below +0).
    function automatic logic [31:0] order_key(input fp32_t x);
        return x.sign ? ~32'(x) : (32'(x) | 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fcmp_if.sv
// Request/response handshake bundle between operand read, the compare stage and writeback.
interface fcmp_if #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned FLAGS_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [31:0]        in_rs1;
    logic [31:0]        in_rs2;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic [FLAGS_W-1:0] out_fflags;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_fflags, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_fflags, out_tag
    );
endinterface

// File: rtl/fcmp_core.sv
// Combinational FEQ/FLT/FLE evaluation with IEEE NaN and signed-zero rules.
// FMIN/FMAX are decoded only when FCMP_MINMAX_EN is defined; otherwise they behave as invalid ops.
module fcmp_core
    import fcmp_pkg::*;
#(
    parameter int unsigned FLAGS_W = 5
) (
    input  logic [31:0]        rs1,
    input  logic [31:0]        rs2,
    input  logic [2:0]         op,
    output logic [31:0]        result,
    output logic [FLAGS_W-1:0] fflags
);
    fp32_t       a, b;
    logic        a_nan, b_nan, any_nan, any_snan, both_zero;
    logic [31:0] key_a, key_b;
    logic        a_lt, a_le;

    assign a         = rs1;
    assign b         = rs2;
    assign a_nan     = is_nan(a);
    assign b_nan     = is_nan(b);
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = is_snan(a) || is_snan(b);
    assign both_zero = is_zero(a) && is_zero(b);
    assign key_a     = order_key(a);
    assign key_b     = order_key(b);
    assign a_lt      = key_a < key_b;
    assign a_le      = key_a <= key_b;

    always_comb begin
        result = '0;
        fflags = '0;
        case (op)
            FCMP_FEQ: begin
                result[0]        = !any_nan && ((a == b) || both_zero);
                fflags[FFLAG_NV] = any_snan;
            end
            FCMP_FLT: begin
                result[0]        = !any_nan && !both_zero && a_lt;
                fflags[FFLAG_NV] = any_nan;
            end
            FCMP_FLE: begin
                result[0]        = !any_nan && (both_zero || a_le);
                fflags[FFLAG_NV] = any_nan;
            end
`ifdef FCMP_MINMAX_EN
            FCMP_FMIN, FCMP_FMAX: begin
                if (a_nan && b_nan)
                    result = CANON_NAN;
                else if (a_nan)
                    result = rs2;
                else if (b_nan)
                    result = rs1;
                // Key order already ranks -0 below +0, so no zero special case is needed.
                else if ((op == FCMP_FMIN) == a_lt)
                    result = rs1;
                else
                    result = rs2;
                fflags[FFLAG_NV] = any_snan;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/fcmp_stage.sv
// Two-stage FP32 compare pipeline: operand register, combinational core, output register.
// Optional FMIN/FMAX support is enabled with FCMP_MINMAX_EN.
module fcmp_stage
    import fcmp_pkg::*;
#(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned FLAGS_W = 5
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  flush,
    fcmp_if.slave bus
);
    logic               s1_valid;
    logic [2:0]         s1_op;
    logic [31:0]        s1_rs1, s1_rs2;
    logic [TAG_W-1:0]   s1_tag;

    logic               out_valid;
    logic [31:0]        out_result;
    logic [FLAGS_W-1:0] out_fflags;
    logic [TAG_W-1:0]   out_tag;

    logic [31:0]        core_result;
    logic [FLAGS_W-1:0] core_fflags;
    logic               s2_load;
    logic               in_ready;

    fcmp_core #(.FLAGS_W(FLAGS_W)) u_core (
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .op     (s1_op),
        .result (core_result),
        .fflags (core_fflags)
    );

    assign s2_load  = !out_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_tag     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_fflags <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= core_result;
                    out_fflags <= core_fflags;
                    out_tag    <= s1_tag;
                end
            end
            if (in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op  <= bus.in_op;
                    s1_rs1 <= bus.in_rs1;
                    s1_rs2 <= bus.in_rs2;
                    s1_tag <= bus.in_tag;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_result;
    assign bus.out_fflags = out_fflags;
    assign bus.out_tag    = out_tag;
endmodule

// File: tb/tb_fcmp_stage.sv
// Self-checking bench for fcmp_stage: directed cases plus randomized traffic against a value-level model.
module tb_fcmp_stage;
    import fcmp_pkg::*;

    localparam int unsigned TAG_W   = 5;
    localparam int unsigned FLAGS_W = 5;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    fcmp_if #(.TAG_W(TAG_W), .FLAGS_W(FLAGS_W)) bus ();

    fcmp_stage #(.TAG_W(TAG_W), .FLAGS_W(FLAGS_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    exp_t       q[$];
    logic [4:0] tag_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Value-level reference: operands become signed magnitudes, so +0 and -0 are the same number.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f);
        logic        na, nb, sa, sb;
        logic signed [32:0] va, vb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        sa = na && !a[22];
        sb = nb && !b[22];
        va = a[31] ? -$signed({2'b00, a[30:0]}) : $signed({2'b00, a[30:0]});
        vb = b[31] ? -$signed({2'b00, b[30:0]}) : $signed({2'b00, b[30:0]});
        r = 32'd0;
        f = 5'd0;
        case (op)
            3'b000: begin r[0] = !(na || nb) && (va <= vb); f[4] = na || nb; end
            3'b001: begin r[0] = !(na || nb) && (va < vb);  f[4] = na || nb; end
            3'b010: begin r[0] = !(na || nb) && (va == vb); f[4] = sa || sb; end
`ifdef FCMP_MINMAX_EN
            3'b100, 3'b101: begin
                if (na && nb)      r = 32'h7FC0_0000;
                else if (na)       r = b;
                else if (nb)       r = a;
                else if (va < vb)  r = (op == 3'b100) ? a : b;
                else if (vb < va)  r = (op == 3'b100) ? b : a;
                else if (op == 3'b100) r = a[31] ? a : b;
                else               r = a[31] ? b : a;
                f[4] = sa || sb;
            end
`endif
            default: ;
        endcase
    endfunction

    // Compare process: every cycle, against the queue of operations the model says are in flight.
    logic        prev_hold = 1'b0;
    logic [31:0] p_res;
    logic [4:0]  p_flg, p_tag;
    logic [31:0] m_res;
    logic [4:0]  m_flg;

    always @(negedge clk) begin
        if (!resetn) begin
            q.delete();
            prev_hold = 1'b0;
        end else begin
            cyc++;
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_result", bus.out_result, p_res);
                chk("hold_fflags", 32'(bus.out_fflags), 32'(p_flg));
                chk("hold_tag", 32'(bus.out_tag), 32'(p_tag));
            end
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || bus.out_ready));
            if (q.size() == 0) begin
                chk("idle_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("out_valid_timing", 32'(bus.out_valid), 32'(cyc >= q[0].acc + 2));
                if (bus.out_valid) begin
                    chk("model_result", bus.out_result, q[0].res);
                    chk("model_fflags", 32'(bus.out_fflags), 32'(q[0].flg));
                    chk("model_tag", 32'(bus.out_tag), 32'(q[0].tag));
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready && !flush;
            p_res = bus.out_result;
            p_flg = bus.out_fflags;
            p_tag = bus.out_tag;
            if (flush) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                    tag_log.push_back(q[0].tag);
                    void'(q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    model(bus.in_op, bus.in_rs1, bus.in_rs2, m_res, m_flg);
                    q.push_back('{res: m_res, flg: m_flg, tag: bus.in_tag, acc: cyc});
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b000;
        bus.in_rs1   = 32'd0;
        bus.in_rs2   = 32'd0;
        bus.in_tag   = 5'd0;
    endtask

    // Called just after a rising edge; returns just after the edge that took the operation.
    task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        logic accepted;
        int   waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        do begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!accepted && waited < 20);
        bus.in_valid = 1'b0;
        if (!accepted) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           input logic [31:0] want_res, input logic [4:0] want_flg);
        bus.out_ready = 1'b1;
        offer(op, a, b, tag);
        chk({name, "_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_result"}, bus.out_result, want_res);
        chk({name, "_fflags"}, 32'(bus.out_fflags), 32'(want_flg));
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    endtask

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {s, 8'hFF, 1'b1, m[21:0]};
            3:       return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3F_FFFF))};
            4:       return {s, 8'hFF, 23'd0};
            5:       return 32'h3F80_0000;
            6:       return 32'hBF80_0000;
            7:       return {s, 8'h00, m};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b;
        logic [4:0]  f;
        int          waited;

        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_fflags", 32'(bus.out_fflags), 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        model(3'b001, 32'h3F80_0000, 32'h4000_0000, r, f);
        chk("pin_model_flt", r, 32'd1);
        model(3'b010, 32'h7F80_0001, 32'h3F80_0000, r, f);
        chk("pin_model_snan_nv", 32'(f), 32'h10);
        model(3'b000, 32'h0000_0000, 32'h8000_0000, r, f);
        chk("pin_model_fle_zero", r, 32'd1);

        run_one("flt_1_2",     FCMP_FLT, 32'h3F80_0000, 32'h4000_0000, 5'd1,  32'd1, 5'b00000);
        run_one("flt_m1_m2",   FCMP_FLT, 32'hBF80_0000, 32'hC000_0000, 5'd2,  32'd0, 5'b00000);
        run_one("feq_m1_m2",   FCMP_FEQ, 32'hBF80_0000, 32'hC000_0000, 5'd3,  32'd0, 5'b00000);
        run_one("flt_m2_m1",   FCMP_FLT, 32'hC000_0000, 32'hBF80_0000, 5'd4,  32'd1, 5'b00000);
        run_one("fle_pz_nz",   FCMP_FLE, 32'h0000_0000, 32'h8000_0000, 5'd5,  32'd1, 5'b00000);
        run_one("feq_pz_nz",   FCMP_FEQ, 32'h0000_0000, 32'h8000_0000, 5'd6,  32'd1, 5'b00000);
        run_one("flt_pz_nz",   FCMP_FLT, 32'h0000_0000, 32'h8000_0000, 5'd7,  32'd0, 5'b00000);
        run_one("fle_2_1",     FCMP_FLE, 32'h4000_0000, 32'h3F80_0000, 5'd8,  32'd0, 5'b00000);
        run_one("feq_qnan",    FCMP_FEQ, 32'h7FC0_0000, 32'h3F80_0000, 5'd9,  32'd0, 5'b00000);
        run_one("feq_snan",    FCMP_FEQ, 32'h7F80_0001, 32'h3F80_0000, 5'd10, 32'd0, 5'b10000);
        run_one("flt_qnan",    FCMP_FLT, 32'h7FC0_0000, 32'h3F80_0000, 5'd11, 32'd0, 5'b10000);
        run_one("invalid_op",  3'b011,   32'h3F80_0000, 32'h4000_0000, 5'd12, 32'd0, 5'b00000);
`ifdef FCMP_MINMAX_EN
        run_one("fmin_nz_pz",  FCMP_FMIN, 32'h8000_0000, 32'h0000_0000, 5'd13, 32'h8000_0000, 5'b00000);
        run_one("fmin_pz_nz",  FCMP_FMIN, 32'h0000_0000, 32'h8000_0000, 5'd14, 32'h8000_0000, 5'b00000);
        run_one("fmax_qnan_2", FCMP_FMAX, 32'h7FC0_0000, 32'h4000_0000, 5'd15, 32'h4000_0000, 5'b00000);
        run_one("fmin_qnan2",  FCMP_FMIN, 32'h7FC0_0000, 32'h7FC0_0000, 5'd16, 32'h7FC0_0000, 5'b00000);
        run_one("fmax_snan_1", FCMP_FMAX, 32'h7F80_0001, 32'h3F80_0000, 5'd17, 32'h3F80_0000, 5'b10000);
`else
        run_one("fmin_absent", FCMP_FMIN, 32'h8000_0000, 32'h0000_0000, 5'd13, 32'd0, 5'b00000);
        run_one("fmax_absent", FCMP_FMAX, 32'h3F80_0000, 32'h4000_0000, 5'd14, 32'd0, 5'b00000);
`endif

        // Backpressure: two ops fill both stages, writeback stalls three cycles.
        repeat (2) @(posedge clk);
        #1;
        tag_log.delete();
        bus.out_ready = 1'b0;
        offer(FCMP_FLT, 32'h3F80_0000, 32'h4000_0000, 5'd21);
        offer(FCMP_FLE, 32'h4000_0000, 32'h3F80_0000, 5'd22);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        fork
            begin
                offer(FCMP_FEQ, 32'h3F80_0000, 32'h3F80_0000, 5'd23);
                offer(FCMP_FLT, 32'hC000_0000, 32'h0000_0000, 5'd24);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_tag_count", 32'(tag_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < tag_log.size()) chk("bp_tag_order", 32'(tag_log[i]), 32'(21 + i));

        // Flush with both stages occupied and a new op offered in the same cycle.
        bus.out_ready = 1'b0;
        offer(FCMP_FLT, 32'h3F80_0000, 32'h4000_0000, 5'd25);
        offer(FCMP_FLT, 32'h3F80_0000, 32'h4000_0000, 5'd26);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 5'd27;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("flush_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Asynchronous reset while a result is being presented.
        offer(FCMP_FEQ, 32'h3F80_0000, 32'h3F80_0000, 5'd28);
        @(posedge clk);
        #1;
        chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        run_one("post_rst_fle", FCMP_FLE, 32'h3F80_0000, 32'h3F80_0000, 5'd29, 32'd1, 5'b00000);

        // Randomized traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            a = rand_fp();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ 32'h0000_0001;
                2:       b = a ^ 32'h8000_0000;
                default: b = rand_fp();
            endcase
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_rs1    = a;
            bus.in_rs2    = b;
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        waited        = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
